// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sequencer
// Description : Clocked stimulus/response stage for a 3-input combinational
//               circuit. It drives the patterns {a,b,c} = 000..111 in order,
//               holding each one for HOLD_CYCLES clocks. It samples z_in once
//               per pattern to build an 8-bit truth table. It then compares
//               that table with exp_tt and reports pass or fail.
//               Optional build macro: TT_SEQ_STOP_ON_MISMATCH_EN
//               (ends the sweep on the first mismatching pattern).
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
    parameter int HOLD_CYCLES = 20          // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] exp_tt,
    input  logic       z_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic [3:0] err_cnt,
    output logic [2:0] first_err_idx,
    output logic       pass
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;
    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] c_IDX_LAST  = 3'd7;

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [7:0] r_hcnt;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_tt;
    logic [3:0] r_err_cnt;
    logic [2:0] r_first_err_idx;
    logic       r_pass;

    logic       w_sample;
    logic       w_mismatch;
    logic [3:0] w_err_next;
    logic       w_stop;
    logic       w_finish;

    // The pattern index is itself the registered pattern output.
    assign a_out         = r_idx[2];
    assign b_out         = r_idx[1];
    assign c_out         = r_idx[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign tt            = r_tt;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_err_idx;
    assign pass          = r_pass;

    // The last clock of each hold window is the sample edge for the pattern.
    assign w_sample   = (r_state == c_ST_RUN) && (r_hcnt == c_HOLD_LAST);
    assign w_mismatch = (z_in != exp_tt[r_idx]);
    assign w_err_next = r_err_cnt + {3'b000, w_mismatch};

`ifdef TT_SEQ_STOP_ON_MISMATCH_EN
    // Abort on the first mismatch; the failing pattern remains on the outputs.
    assign w_stop = w_mismatch;
`else
    // Always sweep all eight patterns.
    assign w_stop = 1'b0;
`endif

    // Index 7 always ends the sweep; the index never wraps.
    assign w_finish = (r_idx == c_IDX_LAST) || w_stop;

    // Sequencer state, pattern index, hold counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_idx           <= 3'd0;
            r_hcnt          <= 8'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_tt            <= 8'd0;
            r_err_cnt       <= 4'd0;
            r_first_err_idx <= 3'd0;
            r_pass          <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state         <= c_ST_RUN;
                        r_idx           <= 3'd0;
                        r_hcnt          <= 8'd0;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_tt            <= 8'd0;
                        r_err_cnt       <= 4'd0;
                        r_first_err_idx <= 3'd0;
                        r_pass          <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    // start is ignored here because the block is busy.
                    if (w_sample) begin
                        r_tt[r_idx] <= z_in;
                        if (w_mismatch) begin
                            r_err_cnt <= w_err_next;
                            if (r_err_cnt == 4'd0) begin
                                r_first_err_idx <= r_idx;
                            end
                        end
                        if (w_finish) begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 4'd0);
                        end else begin
                            r_idx  <= r_idx + 3'd1;
                            r_hcnt <= 8'd0;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
